// File: rtl/key_event_decoder.sv
// ASCII byte to calculator key-event decoder: small input FIFO, classifier and paced pulse FSM.
// Optional ECHO_EN adds an echo_data/echo_valid/echo_ready stream of every decoded event byte.
module key_event_decoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       got_dig,
    output logic       got_op,
    output logic       got_eq,
    output logic       got_esc,
    output logic [3:0] dig_val,
    output logic [1:0] op_code,
    output logic       err_char
`ifdef ECHO_EN
    ,
    output logic [7:0] echo_data,
    output logic       echo_valid,
    input  logic       echo_ready
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          dig_q, dig_d, op_q, op_d, eq_q, eq_d, esc_q, esc_d, err_q, err_d;
    logic [3:0]    dig_val_q, dig_val_d;
    logic [1:0]    op_code_q, op_code_d;
    logic [7:0]    head;
    logic          push, pop, is_event, echo_busy;

`ifdef ECHO_EN
    logic       echo_valid_q, echo_valid_d;
    logic [7:0] echo_data_q, echo_data_d;
    assign echo_busy  = echo_valid_q;
    assign echo_valid = echo_valid_q;
    assign echo_data  = echo_data_q;
`else
    assign echo_busy = 1'b0;
`endif

    assign head     = mem_q[rd_ptr_q];
    assign rx_ready = (count_q != CW'(FIFO_DEPTH));
    assign push     = rx_valid && rx_ready;

    assign got_dig  = dig_q;
    assign got_op   = op_q;
    assign got_eq   = eq_q;
    assign got_esc  = esc_q;
    assign err_char = err_q;
    assign dig_val  = dig_val_q;
    assign op_code  = op_code_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        is_event  = 1'b0;
        dig_d     = 1'b0;
        op_d      = 1'b0;
        eq_d      = 1'b0;
        esc_d     = 1'b0;
        err_d     = 1'b0;
        dig_val_d = dig_val_q;
        op_code_d = op_code_q;
`ifdef ECHO_EN
        echo_data_d  = echo_data_q;
        echo_valid_d = echo_valid_q && !echo_ready;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !echo_busy) begin
                    pop = 1'b1;
                    case (head) inside
                        [8'h30:8'h39]: begin dig_d = 1'b1; dig_val_d = head[3:0]; is_event = 1'b1; end
                        8'h2B: begin op_d = 1'b1; op_code_d = 2'b00; is_event = 1'b1; end
                        8'h2D: begin op_d = 1'b1; op_code_d = 2'b01; is_event = 1'b1; end
                        8'h2A: begin op_d = 1'b1; op_code_d = 2'b10; is_event = 1'b1; end
                        8'h2F: begin op_d = 1'b1; op_code_d = 2'b11; is_event = 1'b1; end
                        8'h3D, 8'h0D:        begin eq_d  = 1'b1; is_event = 1'b1; end
                        8'h1B, 8'h63, 8'h43: begin esc_d = 1'b1; is_event = 1'b1; end
                        8'h0A, 8'h20: ;
                        default: begin err_d = 1'b1; state_d = EMIT; end
                    endcase
                    if (is_event) begin
                        state_d = EMIT;
`ifdef ECHO_EN
                        echo_valid_d = 1'b1;
                        echo_data_d  = head;
`endif
                    end
                end
            end
            EMIT: begin
                gap_d   = GW'(GAP);
                state_d = HOLD;
            end
            HOLD: begin
                // Leave as the counter reaches zero so HOLD spans exactly GAP cycles.
                gap_d = gap_q - GW'(1);
                if (gap_q == GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            gap_q     <= '0;
            dig_q     <= 1'b0;
            op_q      <= 1'b0;
            eq_q      <= 1'b0;
            esc_q     <= 1'b0;
            err_q     <= 1'b0;
            dig_val_q <= '0;
            op_code_q <= '0;
`ifdef ECHO_EN
            echo_valid_q <= 1'b0;
            echo_data_q  <= '0;
`endif
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            gap_q     <= gap_d;
            dig_q     <= dig_d;
            op_q      <= op_d;
            eq_q      <= eq_d;
            esc_q     <= esc_d;
            err_q     <= err_d;
            dig_val_q <= dig_val_d;
            op_code_q <= op_code_d;
`ifdef ECHO_EN
            echo_valid_q <= echo_valid_d;
            echo_data_q  <= echo_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed cases plus random byte streams
// compared in order against a queue-based reference of expected events.
module tb_key_event_decoder;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned GAP        = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       got_dig, got_op, got_eq, got_esc, err_char;
    logic [3:0] dig_val;
    logic [1:0] op_code;
`ifdef ECHO_EN
    logic [7:0] echo_data;
    logic       echo_valid;
    logic       echo_ready = 1'b1;
`endif

    key_event_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .got_dig(got_dig), .got_op(got_op), .got_eq(got_eq), .got_esc(got_esc),
        .dig_val(dig_val), .op_code(op_code), .err_char(err_char)
`ifdef ECHO_EN
        , .echo_data(echo_data), .echo_valid(echo_valid), .echo_ready(echo_ready)
`endif
    );

    always #5 clk = ~clk;

    // mask bit order: dig, op, eq, esc, err
    typedef struct {
        logic [4:0] mask;
        logic [3:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pulse_cyc[$];
    int unsigned n_cmp = 0, n_bad = 0, n_pulse = 0;
    int unsigned cyc = 0, last_cyc = 0;
    bit          have_last = 1'b0, saw_full = 1'b0;
    logic [3:0]  model_dig = '0;
    logic [1:0]  model_op  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit classify(input logic [7:0] b, output exp_t e);
        e.mask = 5'b00000;
        e.val  = 4'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            e.mask = 5'b10000;
            e.val  = 4'(b - 8'h30);
        end else if (b == "+") begin e.mask = 5'b01000; e.val = 4'd0; end
        else if (b == "-")     begin e.mask = 5'b01000; e.val = 4'd1; end
        else if (b == "*")     begin e.mask = 5'b01000; e.val = 4'd2; end
        else if (b == "/")     begin e.mask = 5'b01000; e.val = 4'd3; end
        else if (b == "=" || b == 8'h0D) e.mask = 5'b00100;
        else if (b == 8'h1B || b == "c" || b == "C") e.mask = 5'b00010;
        else if (b == 8'h0A || b == " ") return 1'b0;
        else e.mask = 5'b00001;
        return 1'b1;
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] ops;
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: return 8'(8'h30 + $urandom_range(0, 9));
            4, 5: begin
                case ($urandom_range(0, 3))
                    0: ops = "+";
                    1: ops = "-";
                    2: ops = "*";
                    default: ops = "/";
                endcase
                return ops;
            end
            6: return ($urandom_range(0, 1) != 0) ? 8'h3D : 8'h0D;
            7: begin
                case ($urandom_range(0, 2))
                    0: ops = 8'h1B;
                    1: ops = "c";
                    default: ops = "C";
                endcase
                return ops;
            end
            8: return ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h20;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [4:0] p;
        exp_t e;
        if (rst) begin
            p = {got_dig, got_op, got_eq, got_esc, err_char};
            check("at_most_one_pulse", 32'($countones(p) <= 1), 1);
            if (p != 5'b0) begin
                n_pulse++;
                pulse_cyc.push_back(cyc);
                if (have_last) check("pulse_spacing_ok", 32'((cyc - last_cyc) >= GAP + 2), 1);
                have_last = 1'b1;
                last_cyc  = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(p), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(p), 32'(e.mask));
                    if (e.mask[4]) model_dig = e.val;
                    if (e.mask[3]) model_op  = e.val[1:0];
                end
            end
            check("dig_val", 32'(dig_val), 32'(model_dig));
            check("op_code", 32'(op_code), 32'(model_op));
        end
    end

    // Presents a byte from a negedge and holds it until accepted; returns at the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned waits;
        exp_t e;
        waits = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waits < 100) begin
            saw_full = 1'b1;
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) begin
            check("accept_timeout", 0, 1);
            rx_valid = 1'b0;
            return;
        end
        if (classify(b, e)) exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (GAP + 4) @(negedge clk);
        check(tag, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        logic [7:0] burst [5];
        logic [7:0] fill  [6];
        burst = '{8'h31, 8'h32, 8'h2B, 8'h33, 8'h3D};
        fill  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

        #3 rst = 1'b0;
        #4;
        check("reset_rx_ready", 32'(rx_ready), 1);
        check("reset_pulses", 32'({got_dig, got_op, got_eq, got_esc, err_char}), 0);
        check("reset_dig_val", 32'(dig_val), 0);
        check("reset_op_code", 32'(op_code), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single digit latency: accept edge, one quiet cycle, then the pulse for one cycle
        send_byte(8'h37);
        go_idle();
        check("dig7_not_early", 32'(got_dig), 0);
        @(negedge clk);
        check("dig7_pulse", 32'(got_dig), 1);
        check("dig7_value", 32'(dig_val), 7);
        check("dig7_others", 32'({got_op, got_eq, got_esc, err_char}), 0);
        @(negedge clk);
        check("dig7_one_cycle", 32'(got_dig), 0);
        drain("drain_single");

        pulse_cyc.delete();
        foreach (burst[i]) send_byte(burst[i]);
        go_idle();
        drain("drain_burst");
        check("burst_count", 32'(pulse_cyc.size()), 5);
        for (int i = 1; i < 5 && i < pulse_cyc.size(); i++)
            check("burst_spacing", pulse_cyc[i] - pulse_cyc[i-1], GAP + 2);

        saw_full = 1'b0;
        foreach (fill[i]) send_byte(fill[i]);
        go_idle();
        check("fifo_backpressure_seen", 32'(saw_full), 1);
        drain("drain_full");

        base = n_pulse;
        send_byte(8'h41);
        send_byte(8'h0A);
        send_byte(8'h1B);
        go_idle();
        drain("drain_err_lf_esc");
        check("err_lf_esc_pulses", n_pulse - base, 2);

        // reset between acceptance and pulse
        send_byte(8'h35);
        #2;
        rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        exp_q.delete();
        model_dig = '0;
        model_op  = '0;
        have_last = 1'b0;
        check("midrst_pulses", 32'({got_dig, got_op, got_eq, got_esc, err_char}), 0);
        check("midrst_rx_ready", 32'(rx_ready), 1);
        check("midrst_dig_val", 32'(dig_val), 0);
        base = n_pulse;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_event", n_pulse - base, 0);

        for (int i = 0; i < 300; i++) begin
            int unsigned idle;
            idle = $urandom_range(0, 3);
            send_byte(rand_byte());
            if (idle > 0) begin
                go_idle();
                repeat (idle - 1) @(negedge clk);
            end
        end
        go_idle();
        drain("drain_random");

`ifdef ECHO_EN
        echo_ready = 1'b0;
        base = n_pulse;
        send_byte(8'h39);
        send_byte(8'h34);
        go_idle();
        repeat (12) @(negedge clk);
        check("echo_one_event", n_pulse - base, 1);
        check("echo_valid_held", 32'(echo_valid), 1);
        check("echo_data_held", 32'(echo_data), 32'h39);
        echo_ready = 1'b1;
        drain("drain_echo");
        check("echo_second_event", n_pulse - base, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
